mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port (text/data RAM pair behind the IorD
// address mux) between the multicycle CPU and an external requester
// (debug loader / DMA). One request is latched at a time and sequenced over
// ACC_CYCLES clocks. A registered one-cycle ack then returns with the read data.
// A streak counter keeps the CPU from starving the external port.
//
// Optional feature: define MEM_ARB_LOCK_EN to honour ext_lock (EXT burst lock).
// When it is undefined, ext_lock is accepted but ignored.
//
// Ports:
//   clockCPU, reset        clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU level request and payload
//   cpu_rdata, cpu_ack     CPU read data, valid with the one-cycle ack
//   cpu_stall              cpu_req & ~cpu_ack; holds the CPU control FSM
//   ext_req/we/addr/wdata  external level request and payload
//   ext_lock               external burst lock
//   ext_rdata, ext_ack     external read data, valid with the one-cycle ack
//   mem_addr/wdata/wren    memory-side address, write data and write strobe
//   mem_rdata              memory read data
//   busy                   an access is in progress
module mem_port_arbiter #(
    parameter int unsigned ACC_CYCLES     = 2,
    parameter int unsigned MAX_CPU_STREAK = 4
) (
    input  logic        clockCPU,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic        ext_lock,
    output logic [31:0] ext_rdata,
    output logic        ext_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wren,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam int unsigned STREAK_W = (MAX_CPU_STREAK > 0) ? $clog2(MAX_CPU_STREAK + 1) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(ACC_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        EXT_ACC = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [STREAK_W-1:0] streak, streak_d;
    logic                lat_we, we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_d, ext_rdata_d;
    logic                cpu_ack_d, ext_ack_d;
    logic                wren_d, busy_d;
    logic                grant_cpu, grant_ext;
    logic                lock_hold;

    // Stall is the only combinational output: the CPU must see it in the
    // same cycle it raises cpu_req.
    assign cpu_stall = cpu_req & ~cpu_ack;

`ifdef MEM_ARB_LOCK_EN
    logic last_ext;

    // Remembers whether the most recent grant went to EXT, for burst lock.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            last_ext <= 1'b0;
        end else if (grant_ext) begin
            last_ext <= 1'b1;
        end else if (grant_cpu) begin
            last_ext <= 1'b0;
        end
    end

    assign lock_hold = last_ext & ext_lock;
`else
    logic unused_ext_lock;

    assign unused_ext_lock = ext_lock;
    assign lock_hold       = 1'b0;
`endif

    // Next-state, arbitration and access sequencing.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        streak_d    = streak;
        we_d        = lat_we;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        cpu_rdata_d = cpu_rdata;
        ext_rdata_d = ext_rdata;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;
        wren_d      = 1'b0;
        grant_cpu   = 1'b0;
        grant_ext   = 1'b0;

        case (state)
            IDLE: begin
                // The ack cycle is a turnaround edge: the acked level request
                // is being retired, so no grant is made until the next edge.
                if (!cpu_ack && !ext_ack) begin
                    if (cpu_req && ext_req) begin
                        if (lock_hold || (streak == STREAK_MAX)) begin
                            grant_ext = 1'b1;
                        end else begin
                            grant_cpu = 1'b1;
                        end
                    end else begin
                        grant_cpu = cpu_req;
                        grant_ext = ext_req;
                    end
                end

                if (grant_cpu) begin
                    state_d = CPU_ACC;
                    cnt_d   = '0;
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    wren_d  = cpu_we;
                end else if (grant_ext) begin
                    state_d = EXT_ACC;
                    cnt_d   = '0;
                    we_d    = ext_we;
                    addr_d  = ext_addr;
                    wdata_d = ext_wdata;
                    wren_d  = ext_we;
                end
            end

            CPU_ACC, EXT_ACC: begin
                // Write strobe only ever lives in the first cycle (cnt == 0).
                if (cnt == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (state == CPU_ACC) begin
                        cpu_rdata_d = mem_rdata;
                        cpu_ack_d   = 1'b1;
                    end else begin
                        ext_rdata_d = mem_rdata;
                        ext_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Streak of CPU wins while EXT waits; saturating.
        if (!ext_req || grant_ext) begin
            streak_d = '0;
        end else if (grant_cpu && (streak != STREAK_MAX)) begin
            streak_d = streak + STREAK_W'(1);
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clockCPU or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            streak    <= streak_d;
            lat_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wren  <= wren_d;
            cpu_rdata <= cpu_rdata_d;
            ext_rdata <= ext_rdata_d;
            cpu_ack   <= cpu_ack_d;
            ext_ack   <= ext_ack_d;
            busy      <= busy_d;
        end
    end

endmodule
